// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice (two half adders + OR) fed LSB-first.
// Define SERIAL_ADD_SUB_EN to add an i_sub port selecting op_a - op_b.

module serial_adder_ctrl_ha (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done_valid,
    input  logic             i_done_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_start_ready;
    logic             r_busy;
    logic             r_done_valid;

    logic w_s1;
    logic w_c1;
    logic w_sum;
    logic w_c2;
    logic w_cout;
    logic w_sub;
    logic w_last;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub = i_sub;
`else
    assign w_sub = 1'b0;
`endif

    serial_adder_ctrl_ha u_ha1 (
        .i_a     (r_sh_a[0]),
        .i_b     (r_sh_b[0]),
        .o_sum   (w_s1),
        .o_carry (w_c1)
    );

    serial_adder_ctrl_ha u_ha2 (
        .i_a     (w_s1),
        .i_b     (r_carry),
        .o_sum   (w_sum),
        .o_carry (w_c2)
    );

    assign w_cout = w_c1 | w_c2;
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_sh_a        <= '0;
            r_sh_b        <= '0;
            r_result      <= '0;
            r_cnt         <= '0;
            r_carry       <= 1'b0;
            r_carry_out   <= 1'b0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_done_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start_valid) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry.
                        r_sh_a        <= i_op_a;
                        r_sh_b        <= w_sub ? ~i_op_b : i_op_b;
                        r_carry       <= w_sub;
                        r_cnt         <= '0;
                        r_result      <= '0;
                        r_state       <= RUN;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                RUN: begin
                    r_result <= {w_sum, r_result[WIDTH-1:1]};
                    r_sh_a   <= r_sh_a >> 1;
                    r_sh_b   <= r_sh_b >> 1;
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_carry_out  <= w_cout;
                        r_state      <= DONE;
                        r_busy       <= 1'b0;
                        r_done_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE here delays the next acceptance by one cycle.
                    if (i_done_ready) begin
                        r_done_valid  <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_start_ready <= 1'b1;
                    r_busy        <= 1'b0;
                    r_done_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign o_start_ready = r_start_ready;
    assign o_busy        = r_busy;
    assign o_done_valid  = r_done_valid;
    assign o_result      = r_result;
    assign o_carry_out   = r_carry_out;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8); sub tests only with SERIAL_ADD_SUB_EN.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       sub;
    logic       busy;
    logic       done_valid;
    logic       done_ready;
    logic [7:0] result;
    logic       carry_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start_valid (start_valid),
        .o_start_ready (start_ready),
        .i_op_a        (op_a),
        .i_op_b        (op_b),
`ifdef SERIAL_ADD_SUB_EN
        .i_sub         (sub),
`endif
        .o_busy        (busy),
        .o_done_valid  (done_valid),
        .i_done_ready  (done_ready),
        .o_result      (result),
        .o_carry_out   (carry_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle start pulse; controller must be in IDLE.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
        start_valid = 1'b1;
        op_a = a;
        op_b = b;
        sub = s;
        step();
        start_valid = 1'b0;
    endtask

    // Counts cycles busy is seen high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic release_result();
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] exp_r, input logic exp_c);
        int n;
        issue(a, b, s);
        count_busy(n);
        total++;
        if (n !== 8) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d exp=8", name, n);
        end
        total++;
        if (done_valid !== 1'b1 || result !== exp_r || carry_out !== exp_c) begin
            bad++;
            $display("FAIL %s got dv=%b r=%h c=%b exp dv=1 r=%h c=%b",
                     name, done_valid, result, carry_out, exp_r, exp_c);
        end
        release_result();
        total++;
        if (done_valid !== 1'b0 || start_ready !== 1'b1 || result !== exp_r) begin
            bad++;
            $display("FAIL %s_release got dv=%b sr=%b r=%h exp dv=0 sr=1 r=%h",
                     name, done_valid, start_ready, result, exp_r);
        end
        $display("op %s a=%h b=%h sub=%b -> r=%h c=%b", name, a, b, s, result, carry_out);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_valid = 1'b0;
        done_ready = 1'b0;
        op_a = '0;
        op_b = '0;
        sub = 1'b0;
        step();
        total++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 ||
            result !== 8'h00 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got sr=%b busy=%b dv=%b r=%h c=%b exp 1 0 0 00 0",
                     start_ready, busy, done_valid, result, carry_out);
        end
        #3 rst_n = 1'b1;
        step();
        // Abort mid-RUN after 3 bits of A5+3C.
        issue(8'hA5, 8'h3C, 1'b0);
        step();
        step();
        step();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_midrun_pre busy got=%b exp=1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done_valid !== 1'b0 || start_ready !== 1'b1 || result !== 8'h00) begin
            bad++;
            $display("FAIL reset_async got busy=%b dv=%b sr=%b r=%h exp 0 0 1 00",
                     busy, done_valid, start_ready, result);
        end
        $display("reset mid-run: busy=%b dv=%b sr=%b r=%h", busy, done_valid, start_ready, result);
        #1 rst_n = 1'b1;
        step();
        run_op("after_reset", 8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0);
    endtask

    task automatic test_add();
        run_op("add_a5_3c", 8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0);
        run_op("ripple_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("ripple_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_backpressure();
        int n;
        issue(8'h12, 8'h34, 1'b0);
        start_valid = 1'b1;
        op_a = 8'h11;
        total++;
        if (start_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_run got=%b exp=0", start_ready);
        end
        count_busy(n);
        total++;
        if (done_valid !== 1'b1 || result !== 8'h46 || carry_out !== 1'b0 || start_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_result got dv=%b r=%h c=%b sr=%b exp 1 46 0 0",
                     done_valid, result, carry_out, start_ready);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (done_valid !== 1'b1 || result !== 8'h46 || carry_out !== 1'b0 || start_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got dv=%b r=%h c=%b sr=%b exp 1 46 0 0",
                         i, done_valid, result, carry_out, start_ready);
            end
        end
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || start_ready !== 1'b1 || done_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_turnaround got busy=%b sr=%b dv=%b exp 0 1 0", busy, start_ready, done_valid);
        end
        step();
        start_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_next_accept busy got=%b exp=1", busy);
        end
        count_busy(n);
        total++;
        if (result !== 8'h45 || carry_out !== 1'b0 || done_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_next_result got r=%h c=%b dv=%b exp 45 0 1", result, carry_out, done_valid);
        end
        $display("backpressure: next op 11+34 -> r=%h c=%b", result, carry_out);
        release_result();
    endtask

    task automatic test_back_to_back();
        int n;
        start_valid = 1'b1;
        done_ready = 1'b1;
        op_a = 8'h01;
        op_b = 8'h01;
        step();
        op_a = 8'h7F;
        op_b = 8'h01;
        count_busy(n);
        total++;
        if (n !== 8 || result !== 8'h02 || carry_out !== 1'b0 || done_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got n=%0d r=%h c=%b dv=%b exp 8 02 0 1", n, result, carry_out, done_valid);
        end
        step();
        total++;
        if (busy !== 1'b0 || start_ready !== 1'b1 || done_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got busy=%b sr=%b dv=%b exp 0 1 0", busy, start_ready, done_valid);
        end
        step();
        count_busy(n);
        total++;
        if (n !== 8 || result !== 8'h80 || carry_out !== 1'b0 || done_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second got n=%0d r=%h c=%b dv=%b exp 8 80 0 1", n, result, carry_out, done_valid);
        end
        start_valid = 1'b0;
        step();
        step();
        done_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || start_ready !== 1'b1 || result !== 8'h80) begin
            bad++;
            $display("FAIL b2b_quiet got busy=%b sr=%b r=%h exp 0 1 80", busy, start_ready, result);
        end
        $display("back-to-back: second r=%h c=%b", result, carry_out);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        run_op("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial addition controller built around the team's 1-bit half-adder datapath (ports a, b, sum, carry).
- Holds two WIDTH-bit operands and a carry flip-flop. Feeds one bit pair per clock, LSB first, through two internal half-adder instances plus an OR, which forms a full-adder slice.
- Sequences the operation with a small FSM.
- Exposes valid/ready handshakes on the command and result sides, for use wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset asserted).
- start_valid  input  1  command valid.
- start_ready  output  1  controller can accept a command.
- op_a  input  WIDTH  first operand; sampled on the start handshake.
- op_b  input  WIDTH  second operand; sampled on the start handshake.
- busy  output  1  high while in RUN.
- done_valid  output  1  result available.
- done_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum bits.
- carry_out  output  1  final carry out of bit WIDTH-1.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE and bit counter clears.
  - Shift registers, result, carry flip-flop and carry_out clear to 0.
  - start_ready=1, busy=0, done_valid=0.
- Reset takes effect immediately and aborts any operation in progress. No partial result is ever presented.
- States are IDLE, RUN and DONE.
- IDLE:
  - start_ready=1.
  - Start handshake = start_valid & start_ready at a rising edge.
  - On the handshake: op_a→sh_a, op_b→sh_b, carry flip-flop←0, counter←0, result←0, go to RUN.
- RUN, one bit per cycle, with a=sh_a[0], b=sh_b[0], cin=carry flip-flop:
  - s1=a^b, c1=a&b (half adder 1).
  - sum=s1^cin, c2=s1&cin (half adder 2).
  - cout=c1|c2.
  - At each edge: result shifts right with sum entering at bit WIDTH-1, sh_a and sh_b shift right, carry flip-flop←cout, counter increments.
  - When the counter reaches WIDTH-1 at an edge (the final bit): carry_out←cout and go to DONE.
- Latency: start handshake at edge T0 → done_valid high after edge T0+WIDTH. That is exactly WIDTH RUN cycles.
- DONE:
  - done_valid=1.
  - result and carry_out held stable until done_ready is sampled high.
  - At that edge: done_valid→0, go to IDLE.
  - result and carry_out keep their values until the next start handshake.
- start_ready=0 in RUN and DONE. start_valid is ignored in those states and the operands are not resampled.
- No same-cycle turnaround: a new command is accepted at the earliest one cycle after the result handshake.
- done_ready high in IDLE or RUN has no effect.
- start_valid held high continuously: one command is accepted per IDLE visit.
- Counter width is clog2(WIDTH). The counter never wraps within an operation.
- Operands are treated as unsigned. carry_out is the unsigned overflow.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on the start handshake.
  - When sub=1: sh_b loads ~op_b and the carry flip-flop initialises to 1, so result = op_a - op_b mod 2^WIDTH.
  - In subtraction, carry_out=1 means no borrow (op_a ≥ op_b).
  - Latency and handshake are unchanged.
- Undefined: no sub port; addition only; carry flip-flop always initialises to 0.

Test Plan:
- Reset/idle: reset low mid-RUN (after 3 bits of 0xA5+0x3C) → immediately busy=0, done_valid=0, start_ready=1, result=0x00. After release, a new command completes correctly.
- Basic add, WIDTH=8: op_a=0xA5, op_b=0x3C, start pulse → busy for exactly 8 cycles, then done_valid=1 with result=0xE1, carry_out=0.
- Carry ripple: 0xFF+0x01 → result=0x00, carry_out=1. 0x80+0x80 → result=0x00, carry_out=1.
- Back-pressure: done_ready held low 5 cycles after done_valid → result and done_valid stable. start_valid with op_a=0x11 during RUN and DONE is ignored (start_ready=0). done_ready=1 → IDLE, and the next command is accepted one cycle later.
- Back-to-back: start_valid held high with 0x01+0x01 then 0x7F+0x01 → results 0x02 then 0x80, each with carry_out=0. Exactly one acceptance per IDLE visit.
- SERIAL_ADD_SUB_EN:
  - 0x10-0x01 → result=0x0F, carry_out=1.
  - 0x01-0x02 → result=0xFF, carry_out=0.
  - With the macro undefined, the bench compiles without a sub port.
